lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit controller for the Memory Access (MA) stage of the RISC-V core. It accepts one load or store per instruction from the pipeline and stalls the pipeline while the transaction is in flight. It sequences a single req/ack data-memory port, generating byte enables, replicating store data, and extracting and sign- or zero-extending load data. Misaligned accesses, illegal funct3 encodings, bus errors and bus timeouts are reported as exceptions.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum cycles spent in BUS without ack or err before abort; must be ≥1.
- `clk` in 1: core clock. Single clock domain; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: MA stage holds a load or store. Held stable by the pipeline while `stall_o`=1.
- `req_we_i` in 1: 1 = store (funct3SType_e), 0 = load (funct3ITypeLOAD_e).
- `req_funct3_i` in 3: instruction funct3.
- `req_addr_i` in 32: effective byte address.
- `req_wdata_i` in 32: rs2 value.
- `req_rd_i` in 5: load destination register.
- `flush_i` in 1: kill the current MA instruction.
- `stall_o` out 1: freeze IF..MA.
- `rsp_valid_o` out 1: one-cycle pulse; the access completed.
- `rsp_rdata_o` out 32: extended load data; 0 for stores.
- `rsp_rd_o` out 5: destination register, registered at accept.
- `exc_valid_o` out 1: one-cycle pulse; exception.
- `exc_cause_o` out 2: 00 illegal funct3, 01 load misaligned, 10 store misaligned, 11 bus error or timeout.
- `mem_req_o` out 1, `mem_we_o` out 1, `mem_addr_o` out 32 (word-aligned, bits [1:0]=0), `mem_be_o` out 4, `mem_wdata_o` out 32: memory request.
- `mem_ack_i` in 1, `mem_err_i` in 1, `mem_rdata_i` in 32: memory response.

## Operation
**FSM states:** IDLE, BUS, DONE. Reset returns to IDLE. Reset values of all outputs and registers are 0.

**IDLE**
- `req_valid_i`=1 and `flush_i`=0: register addr, funct3, we, rd, be and wdata.
  - Illegal funct3 (load 011/110/111, store >010) or misaligned access: go to DONE with an exception pending.
  - Otherwise: go to BUS.
- Alignment rules: W requires addr[1:0]=0. H/HU requires addr[0]=0. B is always legal.

**BUS**
- Drive `mem_req_o`=1 and hold all `mem_*` outputs constant until the transaction terminates.
- Exit conditions, in priority order:
  1. `mem_err_i`: exception cause 11.
  2. `mem_ack_i`: latch extracted rdata.
  3. Timeout counter == TIMEOUT_CYCLES-1: abort with cause 11.
- All three exits go to DONE. `mem_req_o` drops in DONE.
- If `flush_i` is seen in any BUS cycle, set a sticky `killed` flag. The bus transaction still completes; it is never abandoned.

**DONE**
- Pulse `rsp_valid_o` or `exc_valid_o`, unless `killed` is set, in which case pulse neither.
- `stall_o`=0. Return to IDLE.

**Byte lanes:** little-endian; byte offset k occupies data bits [8k+7:8k].
- SB: be = 0001<<addr[1:0], wdata = {4{b}}.
- SH: be = 0011<<addr[1:0], wdata = {2{h}}.
- SW: be = 1111, wdata as is.

**Load extract:** shift `mem_rdata_i` right by 8·addr[1:0], then truncate to 8/16/32 bits. LB and LH sign-extend; LBU and LHU zero-extend.

**Stall:** `stall_o` = `req_valid_i` & ~`flush_i` & (state≠DONE).

**Timeout counter:** width $clog2(TIMEOUT_CYCLES+1). Cleared on entering BUS; increments each BUS cycle.

## Timing
- **Aligned access with ack in the first BUS cycle:**
  - cycle 0: IDLE accept.
  - cycle 1: BUS, ack.
  - cycle 2: DONE, `rsp_valid_o`=1.
  - Stall duration: 2 cycles.
- **Each wait cycle** before ack adds 1 cycle.
- **Illegal or misaligned:** exception in cycle 1. No `mem_req_o` is ever driven.
- **Outputs:** `rsp_*`, `exc_*` and `mem_*` are registered. `stall_o` is combinational.
- **Back-to-back:** a new request is accepted in the cycle after DONE, giving a minimum of 3 cycles per access.
- **Reset mid-BUS:** `mem_req_o` falls asynchronously with `rst_n`. The memory slave must tolerate the abandoned request.
- **Simultaneous `mem_ack_i` and `mem_err_i`:** error wins, and rdata is discarded.

## Structure
- Add to package `riscv_definitions`:
  - `lsuState_e` {IDLE, BUS, DONE}.
  - `lsuExcCause_e` {EXC_ILLEGAL, EXC_LD_MISAL, EXC_ST_MISAL, EXC_BUS}.
- Reuse the existing `funct3ITypeLOAD_e`, `funct3SType_e` and `dataBus_u` types.
- Sub-module `lsu_align`: purely combinational. It computes be, replicated wdata, the misalignment and illegal flags, and the extended load data. `lsu_ctrl` holds the FSM, timeout counter and registers.

## Test plan
1. SW, addr 0x100, wdata 0xDEADBEEF, ack in cycle 1 -> `mem_addr_o`=0x100, `mem_be_o`=1111, `mem_wdata_o`=0xDEADBEEF. `stall_o` high in cycles 0–1; `rsp_valid_o` in cycle 2.
2. LB, addr 0x203, `mem_rdata_i`=0x8A000000 -> `rsp_rdata_o`=0xFFFFFF8A and `rsp_rd_o` equals `req_rd_i`. The same access as LBU -> 0x0000008A.
3. SH, addr 0x102, wdata 0x00001234 -> `mem_be_o`=1100, `mem_wdata_o`=0x12341234, `mem_addr_o`=0x100. Then LW at 0x101 -> no `mem_req_o`; cycle 1 gives `exc_valid_o`=1 with `exc_cause_o`=01.
4. LW with no ack, TIMEOUT_CYCLES=16 -> `mem_req_o` high for exactly 16 cycles, then `exc_cause_o`=11. Also: `mem_err_i` together with `mem_ack_i` -> cause 11 and no `rsp_valid_o`.
5. LH, funct3=011 -> cause 00. Store with funct3=100 -> cause 00.
6. `flush_i` in the second BUS cycle, ack in the fourth -> the transaction completes and neither pulse fires. Separately, `rst_n` low mid-BUS -> `mem_req_o`=0 immediately and state returns to IDLE.

Source files
------------

// File: rtl/riscv_definitions.sv
// Shared RISC-V core types: funct3 encodings, data bus view, LSU state and cause codes.
package riscv_definitions;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } funct3ITypeLOAD_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } funct3SType_e;

  typedef union packed {
    logic [31:0]      word;
    logic [1:0][15:0] half;
    logic [3:0][7:0]  bytes;
  } dataBus_u;

  typedef enum logic [1:0] {IDLE, BUS, DONE} lsuState_e;

  typedef enum logic [1:0] {
    EXC_ILLEGAL  = 2'b00,
    EXC_LD_MISAL = 2'b01,
    EXC_ST_MISAL = 2'b10,
    EXC_BUS      = 2'b11
  } lsuExcCause_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: request-side be/wdata/legality and response-side load extraction.
module lsu_align
  import riscv_definitions::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        illegal_o,
  output logic        misal_o,
  output logic [31:0] rdata_o
);

  dataBus_u wd;
  dataBus_u rd_sh;

  assign wd    = wdata_i;
  assign rd_sh = rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    be_o      = 4'b0000;
    wdata_o   = wd.word;
    misal_o   = 1'b0;
    if (we_i) illegal_o = (funct3_i > SW);
    else      illegal_o = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
    // funct3[1:0] encodes the access size for both loads and stores
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wd.bytes[0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{wd.half[0]}};
        misal_o = addr_lo_i[0];
      end
      2'b10: begin
        be_o    = 4'b1111;
        misal_o = |addr_lo_i;
      end
      default: be_o = 4'b0000;
    endcase
  end

  always_comb begin
    case (funct3ITypeLOAD_e'(ld_funct3_i))
      LB:      rdata_o = {{24{rd_sh.bytes[0][7]}}, rd_sh.bytes[0]};
      LH:      rdata_o = {{16{rd_sh.half[0][15]}}, rd_sh.half[0]};
      LW:      rdata_o = rd_sh.word;
      LBU:     rdata_o = {24'b0, rd_sh.bytes[0]};
      LHU:     rdata_o = {16'b0, rd_sh.half[0]};
      default: rdata_o = 32'b0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// MA-stage load/store controller: one req/ack memory transaction per instruction, with stall,
// timeout and exception reporting.
module lsu_ctrl
  import riscv_definitions::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic [4:0]  rsp_rd_o,
  output logic        exc_valid_o,
  output logic [1:0]  exc_cause_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic        mem_err_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsuState_e        state_q, state_d;
  lsuExcCause_e     cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]       be_q, be_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic [4:0]       rd_q, rd_d;
  logic             we_q, we_d, req_q, req_d, killed_q, killed_d;
  logic             rsp_q, rsp_d, exc_q, exc_d;

  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;
  logic        al_illegal, al_misal;

  lsu_align u_align (
    .we_i        (req_we_i),
    .funct3_i    (req_funct3_i),
    .addr_lo_i   (req_addr_i[1:0]),
    .wdata_i     (req_wdata_i),
    .ld_funct3_i (funct3_q),
    .ld_off_i    (off_q),
    .rdata_i     (mem_rdata_i),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .illegal_o   (al_illegal),
    .misal_o     (al_misal),
    .rdata_o     (al_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    be_d     = be_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    rd_d     = rd_q;
    we_d     = we_q;
    killed_d = killed_q;
    rsp_d    = 1'b0;
    exc_d    = 1'b0;
    case (state_q)
      IDLE: begin
        killed_d = 1'b0;
        if (req_valid_i && !flush_i) begin
          addr_d   = {req_addr_i[31:2], 2'b00};
          off_d    = req_addr_i[1:0];
          funct3_d = req_funct3_i;
          we_d     = req_we_i;
          rd_d     = req_rd_i;
          be_d     = al_be;
          wdata_d  = al_wdata;
          cnt_d    = '0;
          if (al_illegal) begin
            state_d = DONE;
            exc_d   = 1'b1;
            cause_d = EXC_ILLEGAL;
          end else if (al_misal) begin
            state_d = DONE;
            exc_d   = 1'b1;
            cause_d = req_we_i ? EXC_ST_MISAL : EXC_LD_MISAL;
          end else begin
            state_d = BUS;
          end
        end
      end
      BUS: begin
        cnt_d    = cnt_q + 1'b1;
        // a flush in the terminating cycle must also suppress the pulse
        killed_d = killed_q | flush_i;
        if (mem_err_i) begin
          state_d = DONE;
          exc_d   = ~killed_d;
          cause_d = EXC_BUS;
          rdata_d = '0;
        end else if (mem_ack_i) begin
          state_d = DONE;
          rsp_d   = ~killed_d;
          rdata_d = we_q ? 32'b0 : al_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          exc_d   = ~killed_d;
          cause_d = EXC_BUS;
          rdata_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_d = (state_d == BUS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cause_q  <= EXC_ILLEGAL;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      be_q     <= '0;
      funct3_q <= '0;
      off_q    <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      req_q    <= 1'b0;
      killed_q <= 1'b0;
      rsp_q    <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      be_q     <= be_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      req_q    <= req_d;
      killed_q <= killed_d;
      rsp_q    <= rsp_d;
      exc_q    <= exc_d;
    end
  end

  assign stall_o     = req_valid_i & ~flush_i & (state_q != DONE);
  assign rsp_valid_o = rsp_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_rd_o    = rd_q;
  assign exc_valid_o = exc_q;
  assign exc_cause_o = cause_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed accesses push expected responses; a monitor pops on pulses.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_we_i, flush_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        stall_o, rsp_valid_o, exc_valid_o;
  logic [31:0] rsp_rdata_o;
  logic [4:0]  rsp_rd_o;
  logic [1:0]  exc_cause_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i, mem_err_i;
  logic [31:0] mem_rdata_i;

  lsu_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
    .flush_i(flush_i), .stall_o(stall_o),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_rd_o(rsp_rd_o),
    .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  localparam int K_RSP = 0, K_EXC = 1, K_NONE = 2;
  localparam int M_ACK = 0, M_ERR = 1, M_NONE = 2;

  typedef struct {
    logic        exc;
    logic [1:0]  cause;
    logic [31:0] rdata;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (rsp_valid_o || exc_valid_o)) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {30'b0, rsp_valid_o, exc_valid_o}, 32'h0);
        end else begin
          e = sb.pop_front();
          if (e.exc) begin
            chk("exc_cause", {30'b0, exc_cause_o}, {30'b0, e.cause});
          end else begin
            chk("rsp_rdata", rsp_rdata_o, e.rdata);
            chk("rsp_rd", {27'b0, rsp_rd_o}, {27'b0, e.rd});
          end
        end
      end
    end
  endtask

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                        input int ack_wait, input int mode, input int flush_at,
                        input int exp_nreq, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input int kind, input logic [1:0] exp_cause, input logic [31:0] exp_rdata);
    int   nreq;
    logic ended;
    exp_t e;
    @(negedge clk);
    #1 chk("sb_drained", sb.size(), 0);
    if (kind != K_NONE) begin
      e.exc = (kind == K_EXC); e.cause = exp_cause; e.rdata = exp_rdata; e.rd = rd;
      sb.push_back(e);
    end
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3; req_addr_i = addr;
    req_wdata_i = wdata; req_rd_i = rd; flush_i = 1'b0; mem_ack_i = 1'b0; mem_err_i = 1'b0;
    #1 chk("stall_accept", stall_o, 1);
    nreq  = 0;
    ended = 1'b0;
    for (int c = 0; c < 40 && !ended; c++) begin
      @(negedge clk);
      mem_ack_i = 1'b0; mem_err_i = 1'b0; flush_i = 1'b0;
      if (!mem_req_o) begin
        ended = 1'b1;
      end else begin
        chk("mem_we", mem_we_o, we);
        chk("mem_addr", mem_addr_o, {addr[31:2], 2'b00});
        chk("mem_be", mem_be_o, exp_be);
        chk("mem_wdata", mem_wdata_o, exp_wd);
        #1 chk("stall_bus", stall_o, 1);
        if (nreq == flush_at) flush_i = 1'b1;
        if (mode != M_NONE && nreq == ack_wait) begin
          mem_ack_i = 1'b1; mem_err_i = (mode == M_ERR); mem_rdata_i = rdata;
        end
        nreq++;
      end
    end
    chk("bus_terminated", ended, 1);
    chk("req_cycles", nreq, exp_nreq);
    chk("done_pulses", {30'b0, rsp_valid_o, exc_valid_o},
        (kind == K_RSP) ? 32'h2 : (kind == K_EXC) ? 32'h1 : 32'h0);
    #1 chk("stall_done", stall_o, 0);
    req_valid_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid_i = 0; req_we_i = 0; req_funct3_i = 0; req_addr_i = 0; req_wdata_i = 0;
    req_rd_i = 0; flush_i = 0; mem_ack_i = 0; mem_err_i = 0; mem_rdata_i = 0;
    fork monitor(); join_none
    @(negedge clk); @(negedge clk);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_exc_valid", exc_valid_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_rsp_rd", {27'b0, rsp_rd_o}, 0);
    rst_n = 1'b1;

    //     we f3      addr          wdata          rd     rdata          wait mode    fl  nreq be       wdata          kind   cause  rdata
    access(1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd3,  32'h0,        0, M_ACK, -1, 1, 4'b1111, 32'hDEADBEEF, K_RSP, 2'b00, 32'h0);
    access(0, 3'b000, 32'h203, 32'h0,        5'd7,  32'h8A000000, 0, M_ACK, -1, 1, 4'b1000, 32'h0,        K_RSP, 2'b00, 32'hFFFFFF8A);
    access(0, 3'b100, 32'h203, 32'h0,        5'd8,  32'h8A000000, 0, M_ACK, -1, 1, 4'b1000, 32'h0,        K_RSP, 2'b00, 32'h0000008A);
    access(1, 3'b001, 32'h102, 32'h00001234, 5'd9,  32'h0,        0, M_ACK, -1, 1, 4'b1100, 32'h12341234, K_RSP, 2'b00, 32'h0);
    access(0, 3'b010, 32'h101, 32'h0,        5'd10, 32'h0,        0, M_ACK, -1, 0, 4'b0000, 32'h0,        K_EXC, 2'b01, 32'h0);
    access(0, 3'b101, 32'h202, 32'h0,        5'd4,  32'h80010000, 0, M_ACK, -1, 1, 4'b1100, 32'h0,        K_RSP, 2'b00, 32'h00008001);
    access(0, 3'b001, 32'h202, 32'h0,        5'd5,  32'h80010000, 1, M_ACK, -1, 2, 4'b1100, 32'h0,        K_RSP, 2'b00, 32'hFFFF8001);
    access(1, 3'b000, 32'h101, 32'h000000AB, 5'd6,  32'h0,        0, M_ACK, -1, 1, 4'b0010, 32'hABABABAB, K_RSP, 2'b00, 32'h0);
    access(0, 3'b010, 32'h308, 32'h0,        5'd20, 32'h12345678, 2, M_ACK, -1, 3, 4'b1111, 32'h0,        K_RSP, 2'b00, 32'h12345678);
    access(0, 3'b010, 32'h300, 32'h0,        5'd11, 32'h0,        0, M_NONE,-1, 16,4'b1111, 32'h0,        K_EXC, 2'b11, 32'h0);
    access(0, 3'b010, 32'h304, 32'h0,        5'd12, 32'h55555555, 1, M_ERR, -1, 2, 4'b1111, 32'h0,        K_EXC, 2'b11, 32'h0);
    access(0, 3'b011, 32'h100, 32'h0,        5'd13, 32'h0,        0, M_ACK, -1, 0, 4'b0000, 32'h0,        K_EXC, 2'b00, 32'h0);
    access(1, 3'b100, 32'h100, 32'h77,       5'd14, 32'h0,        0, M_ACK, -1, 0, 4'b0000, 32'h0,        K_EXC, 2'b00, 32'h0);
    access(1, 3'b001, 32'h103, 32'h5678,     5'd15, 32'h0,        0, M_ACK, -1, 0, 4'b0000, 32'h0,        K_EXC, 2'b10, 32'h0);
    access(0, 3'b010, 32'h400, 32'h0,        5'd16, 32'hCAFEF00D, 3, M_ACK,  1, 4, 4'b1111, 32'h0,        K_NONE,2'b00, 32'h0);

    // reset while the bus request is outstanding
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h500;
    req_rd_i = 5'd17;
    @(negedge clk); @(negedge clk);
    chk("rst_pre_req", mem_req_o, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_req_drop", mem_req_o, 0);
    chk("rst_stall_idle", stall_o, 1);
    req_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    access(0, 3'b010, 32'h504, 32'h0,        5'd31, 32'h0BADF00D, 0, M_ACK, -1, 1, 4'b1111, 32'h0,        K_RSP, 2'b00, 32'h0BADF00D);

    repeat (3) @(negedge clk);
    #1 chk("sb_final_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
